// File: rtl/datapath_storage_if.sv
// Bus bundle for datapath_storage: program load, fetch, register file and data memory ports.
interface datapath_storage_if #(
  parameter int unsigned IM_AW = 8
);
  logic             im_we;
  logic [IM_AW-1:0] im_waddr;
  logic [15:0]      im_wdata;
  logic [15:0]      pc;
  logic [15:0]      instr;
  logic [2:0]       rs;
  logic [2:0]       rt;
  logic [2:0]       wr;
  logic [15:0]      wd;
  logic             rf_we;
  logic [15:0]      rd1;
  logic [15:0]      rd2;
  logic [15:0]      dm_addr;
  logic [15:0]      dm_wdata;
  logic             mem_write;
  logic             mem_read;
  logic [15:0]      read_data;

  modport master (
    output im_we, im_waddr, im_wdata, pc,
    output rs, rt, wr, wd, rf_we,
    output dm_addr, dm_wdata, mem_write, mem_read,
    input  instr, rd1, rd2, read_data
  );

  modport slave (
    input  im_we, im_waddr, im_wdata, pc,
    input  rs, rt, wr, wd, rf_we,
    input  dm_addr, dm_wdata, mem_write, mem_read,
    output instr, rd1, rd2, read_data
  );
endinterface

// File: rtl/datapath_storage.sv
// Storage for a small 16-bit datapath: instruction memory, 8-entry register file, data memory.
// Reads are combinational; all writes commit on the rising clock edge.
module datapath_storage #(
  parameter int unsigned IM_AW = 8,
  parameter int unsigned DM_AW = 8
) (
  input  logic             clk,
  input  logic             reset,
  datapath_storage_if.slave bus
);

  localparam int unsigned IM_DEPTH = 32'd1 << IM_AW;
  localparam int unsigned DM_DEPTH = 32'd1 << DM_AW;
  localparam int unsigned NUM_REGS = 8;

  logic [15:0] imem [IM_DEPTH];
  logic [15:0] regs [NUM_REGS];
  logic [15:0] dmem [DM_DEPTH];

  logic [IM_AW-1:0] fetch_idx;
  logic [DM_AW-1:0] dm_idx;
  logic [15:0]      unused_addr_bits;

  // Upper address bits are dropped so both memories alias modulo their depth.
  assign fetch_idx        = bus.pc[IM_AW-1:0];
  assign dm_idx           = bus.dm_addr[DM_AW-1:0];
  assign unused_addr_bits = bus.pc ^ bus.dm_addr;

  // Program-load port; deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (bus.im_we) begin
      imem[bus.im_waddr] <= bus.im_wdata;
    end
  end

  // Register file; entry 0 is cleared at reset and never written, so it reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.rf_we && (bus.wr != 3'd0)) begin
      regs[bus.wr] <= bus.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DM_DEPTH); i++) begin
        dmem[i] <= '0;
      end
    end else if (bus.mem_write) begin
      dmem[dm_idx] <= bus.dm_wdata;
    end
  end

  // No bypass: reads see the pre-edge contents during a same-cycle write.
  always_comb begin
    bus.instr     = imem[fetch_idx];
    bus.rd1       = regs[bus.rs];
    bus.rd2       = regs[bus.rt];
    bus.read_data = bus.mem_read ? dmem[dm_idx] : 16'h0000;
  end

endmodule

// File: tb/tb_datapath_storage.sv
// Scoreboard bench for datapath_storage: directed scenarios plus a randomized phase
// checked against a behavioural model of the three storage arrays.
module tb_datapath_storage;

  localparam int unsigned IM_AW = 8;
  localparam int unsigned DM_AW = 8;

  localparam int SEL_INSTR = 0;
  localparam int SEL_RD1   = 1;
  localparam int SEL_RD2   = 2;
  localparam int SEL_RDATA = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic reset;

  datapath_storage_if #(.IM_AW(IM_AW)) bus ();

  datapath_storage #(.IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t        sb [$];
  int          checks;
  int          errors;
  logic [15:0] imem_m [256];
  logic [15:0] regs_m [8];
  logic [15:0] dmem_m [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then pop every pending expectation.
  task automatic compare_outputs();
    exp_t        e;
    logic [15:0] got;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_INSTR: got = bus.instr;
        SEL_RD1:   got = bus.rd1;
        SEL_RD2:   got = bus.rd2;
        default:   got = bus.read_data;
      endcase
      check_val(e.tag, got, e.val);
    end
  endtask

  // Advance one clock and mirror the same edge in the model.
  task automatic edge_commit();
    @(posedge clk);
    if (bus.im_we) imem_m[bus.im_waddr] = bus.im_wdata;
    if (reset) begin
      foreach (regs_m[i]) regs_m[i] = 16'h0000;
      foreach (dmem_m[i]) dmem_m[i] = 16'h0000;
    end else begin
      if (bus.rf_we && bus.wr != 3'd0) regs_m[bus.wr] = bus.wd;
      if (bus.mem_write) dmem_m[bus.dm_addr[7:0]] = bus.dm_wdata;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.im_we     = 1'b0;
    bus.im_waddr  = '0;
    bus.im_wdata  = '0;
    bus.pc        = '0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.wr        = '0;
    bus.wd        = '0;
    bus.rf_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (imem_m[i]) imem_m[i] = 16'h0000;
    foreach (regs_m[i]) regs_m[i] = 16'h0000;
    foreach (dmem_m[i]) dmem_m[i] = 16'h0000;
    idle_inputs();
    reset = 1'b1;

    // Program load while reset is asserted.
    @(posedge clk); #1;
    bus.im_we = 1'b1; bus.im_waddr = 8'd0; bus.im_wdata = 16'h4A25;
    edge_commit();
    bus.im_waddr = 8'd1; bus.im_wdata = 16'h8001;
    edge_commit();
    for (int a = 2; a < 16; a++) begin
      bus.im_waddr = 8'(a);
      bus.im_wdata = 16'($urandom);
      edge_commit();
    end
    bus.im_we = 1'b0;
    reset = 1'b0;

    // Post-reset state and instruction fetch aliasing.
    bus.rs = 3'd3; bus.rt = 3'd5; bus.mem_read = 1'b1; bus.dm_addr = 16'h0010; bus.pc = 16'h0001;
    push_exp("rst_rd1", SEL_RD1, 16'h0000);
    push_exp("rst_rd2", SEL_RD2, 16'h0000);
    push_exp("rst_rdata", SEL_RDATA, 16'h0000);
    push_exp("fetch_pc1", SEL_INSTR, 16'h8001);
    compare_outputs();
    bus.pc = 16'h0101;
    push_exp("fetch_alias", SEL_INSTR, 16'h8001);
    compare_outputs();
    bus.pc = 16'h0000;
    push_exp("fetch_pc0", SEL_INSTR, 16'h4A25);
    compare_outputs();
    bus.mem_read = 1'b0;

    // Register write with no bypass, then a write to r0 is dropped.
    bus.rf_we = 1'b1; bus.wr = 3'd3; bus.wd = 16'hBEEF; bus.rs = 3'd3;
    push_exp("rf_pre_edge", SEL_RD1, 16'h0000);
    compare_outputs();
    edge_commit();
    push_exp("rf_post_edge", SEL_RD1, 16'hBEEF);
    compare_outputs();
    bus.wr = 3'd0; bus.wd = 16'h1234; bus.rs = 3'd0; bus.rt = 3'd3;
    edge_commit();
    bus.rf_we = 1'b0;
    push_exp("rf_r0_zero", SEL_RD1, 16'h0000);
    push_exp("rf_rt_r3", SEL_RD2, 16'hBEEF);
    compare_outputs();

    // Data memory write/read and read gating.
    bus.mem_write = 1'b1; bus.dm_addr = 16'h0010; bus.dm_wdata = 16'h00FF;
    edge_commit();
    bus.mem_write = 1'b0; bus.mem_read = 1'b1;
    push_exp("dm_read", SEL_RDATA, 16'h00FF);
    compare_outputs();
    bus.dm_addr = 16'h0110;
    push_exp("dm_alias", SEL_RDATA, 16'h00FF);
    compare_outputs();
    bus.mem_read = 1'b0;
    push_exp("dm_gated", SEL_RDATA, 16'h0000);
    compare_outputs();

    // Simultaneous read and write to the same address.
    bus.mem_write = 1'b1; bus.dm_addr = 16'h0005; bus.dm_wdata = 16'h0001;
    edge_commit();
    bus.mem_read = 1'b1; bus.dm_wdata = 16'h0002;
    push_exp("rw_pre_edge", SEL_RDATA, 16'h0001);
    compare_outputs();
    edge_commit();
    bus.mem_write = 1'b0;
    push_exp("rw_post_edge", SEL_RDATA, 16'h0002);
    compare_outputs();

    // Randomized traffic with all three write ports exercised together.
    for (int n = 0; n < 60; n++) begin
      bus.rf_we     = 1'($urandom);
      bus.wr        = 3'($urandom);
      bus.wd        = 16'($urandom);
      bus.rs        = 3'($urandom);
      bus.rt        = 3'($urandom);
      bus.mem_write = 1'($urandom);
      bus.mem_read  = ($urandom_range(3, 0) != 0);
      bus.dm_addr   = {8'($urandom), 4'h0, 4'($urandom)};
      bus.dm_wdata  = 16'($urandom);
      bus.im_we     = 1'($urandom);
      bus.im_waddr  = 8'($urandom_range(15, 2));
      bus.im_wdata  = 16'($urandom);
      bus.pc        = {8'($urandom), 4'h0, 4'($urandom)};
      push_exp("rnd_instr", SEL_INSTR, imem_m[bus.pc[7:0]]);
      push_exp("rnd_rd1", SEL_RD1, regs_m[bus.rs]);
      push_exp("rnd_rd2", SEL_RD2, regs_m[bus.rt]);
      push_exp("rnd_rdata", SEL_RDATA, bus.mem_read ? dmem_m[bus.dm_addr[7:0]] : 16'h0000);
      compare_outputs();
      edge_commit();
    end
    idle_inputs();

    // Re-establish known contents, then reset with writes pending.
    bus.rf_we = 1'b1; bus.wr = 3'd3; bus.wd = 16'hBEEF;
    bus.mem_write = 1'b1; bus.dm_addr = 16'h0010; bus.dm_wdata = 16'h00FF;
    edge_commit();
    reset = 1'b1;
    bus.rf_we = 1'b1; bus.wr = 3'd2; bus.wd = 16'h7777;
    bus.mem_write = 1'b1; bus.dm_addr = 16'h0010; bus.dm_wdata = 16'h5555;
    edge_commit();
    reset = 1'b0;
    idle_inputs();
    bus.rs = 3'd2; bus.rt = 3'd3; bus.mem_read = 1'b1; bus.dm_addr = 16'h0010; bus.pc = 16'h0000;
    push_exp("rst_prio_r2", SEL_RD1, 16'h0000);
    push_exp("rst_clr_r3", SEL_RD2, 16'h0000);
    push_exp("rst_clr_dm16", SEL_RDATA, 16'h0000);
    push_exp("rst_keep_imem", SEL_INSTR, 16'h4A25);
    compare_outputs();
    bus.pc = 16'h0001;
    push_exp("rst_keep_imem1", SEL_INSTR, imem_m[1]);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_storage.md
DATAPATH_STORAGE -- requirements
Module: datapath_storage

Interface
REQ-001 The block SHALL have parameter IM_AW, default 8, meaning instruction memory address bits (depth 2^IM_AW words of 16 bits).
REQ-002 The block SHALL have parameter DM_AW, default 8, meaning data memory address bits (depth 2^DM_AW words of 16 bits).
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have im_we, input, 1 bit: instruction memory program-load write enable.
REQ-006 The block SHALL have im_waddr, input, IM_AW bits: instruction memory load address (word index).
REQ-007 The block SHALL have im_wdata, input, 16 bits: instruction memory load data.
REQ-008 The block SHALL have pc, input, 16 bits: instruction fetch address (word index).
REQ-009 The block SHALL have instr, output, 16 bits: the fetched instruction.
REQ-010 The block SHALL have rs and rt, inputs, 3 bits each: register file read addresses.
REQ-011 The block SHALL have wr, input, 3 bits: register file write address.
REQ-012 The block SHALL have wd, input, 16 bits: register file write data.
REQ-013 The block SHALL have rf_we, input, 1 bit: register file write enable.
REQ-014 The block SHALL have rd1 and rd2, outputs, 16 bits each: register contents addressed by rs and rt.
REQ-015 The block SHALL have dm_addr, input, 16 bits: data memory address (word index).
REQ-016 The block SHALL have dm_wdata, input, 16 bits: data memory write data.
REQ-017 The block SHALL have mem_write, input, 1 bit: data memory write enable.
REQ-018 The block SHALL have mem_read, input, 1 bit: data memory read enable.
REQ-019 The block SHALL have read_data, output, 16 bits: data memory read result.

Function
REQ-020 instr SHALL equal imem[pc[IM_AW-1:0]] combinationally; upper pc bits are ignored, so addresses alias modulo the depth.
REQ-021 When im_we=1 at a rising edge, imem[im_waddr] SHALL take the value of im_wdata.
REQ-022 Register file: 8 x 16-bit registers; rd1=reg[rs] and rd2=reg[rt], both read combinationally.
REQ-023 When rf_we=1 and wr!=0 at a rising edge, reg[wr] SHALL take the value of wd.
REQ-024 reg[0] SHALL always read 0; writes to register 0 SHALL be ignored.
REQ-025 There SHALL be no write-to-read bypass: in the cycle of a write, reads return the old value, and the new value appears after the edge.
REQ-026 When mem_read=1, read_data SHALL equal dmem[dm_addr[DM_AW-1:0]] combinationally; when mem_read=0, read_data SHALL be 0.
REQ-027 When mem_write=1 at a rising edge, dmem[dm_addr[DM_AW-1:0]] SHALL take the value of dm_wdata; upper address bits are ignored.
REQ-028 With mem_read=1 and mem_write=1 simultaneously, read_data SHALL show the pre-edge contents, and the write SHALL commit at the edge.
REQ-029 Ports rf_we, mem_write and im_we SHALL be independent, and any combination SHALL be allowed in the same cycle.

Reset
REQ-030 reset=1 at a rising edge SHALL clear all 8 registers and all dmem words to 0.
REQ-031 Reset SHALL take priority over rf_we and mem_write in the same edge, so no write occurs.
REQ-032 imem SHALL NOT be affected by reset, and im_we SHALL remain functional during reset.
REQ-033 After reset, rd1, rd2 and read_data SHALL be 0, and instr SHALL reflect the current imem contents.

Verification
REQ-034 Load imem[0]=16'h4A25 and imem[1]=16'h8001; then pc=1 -> instr=16'h8001, and pc=16'h0101 -> instr=imem[1]=16'h8001 (alias).
REQ-035 Reset, then rf_we=1, wr=3, wd=16'hBEEF, rs=3 -> rd1=0 before the edge and 16'hBEEF after it; wr=0, wd=16'h1234 -> rd1 with rs=0 stays 0.
REQ-036 mem_write=1, dm_addr=16'h0010, dm_wdata=16'h00FF, then mem_read=1 -> read_data=16'h00FF; with mem_read=0 -> read_data=0.
REQ-037 Simultaneous mem_read=1 and mem_write=1 to address 5 (old value 16'h0001, new 16'h0002) -> read_data=16'h0001 before the edge and 16'h0002 after it.
REQ-038 reset=1 together with rf_we=1 (wr=2, wd=16'h7777) -> reg[2]=0 after the edge; previously written reg[3] and dmem[16] read 0; imem[0] still reads 16'h4A25.
